// File: rtl/dequant_pkg.sv
// Shared types and constants for the INT4->INT8 dequantization stream controller.
package dequant_pkg;

  localparam int NIB_W = 4;
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic signed [8:0] UNS_MIN = 9'sd0;
  localparam logic signed [8:0] UNS_MAX = 9'sd255;
  localparam logic signed [8:0] SGN_MIN = -9'sd128;
  localparam logic signed [8:0] SGN_MAX = 9'sd127;

endpackage

// File: rtl/dequant_lane.sv
// Combinational lane: (nibble - offset) * scale, clamped to 8 bits.
// DEQ_SIGNED_OUT_EN selects a two's-complement clamp instead of the unsigned one.
module dequant_lane
  import dequant_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  input  logic [NIB_W-1:0] scale,
  input  logic [NIB_W-1:0] offset,
  output logic [OUT_W-1:0] result
);

  logic signed [4:0] diff;
  logic signed [8:0] prod;

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [8:0] p);
`ifdef DEQ_SIGNED_OUT_EN
    if (p < SGN_MIN) return SGN_MIN[OUT_W-1:0];
    else if (p > SGN_MAX) return SGN_MAX[OUT_W-1:0];
`else
    if (p < UNS_MIN) return UNS_MIN[OUT_W-1:0];
    else if (p > UNS_MAX) return UNS_MAX[OUT_W-1:0];
`endif
    return p[OUT_W-1:0];
  endfunction

  assign diff   = $signed({1'b0, nib}) - $signed({1'b0, offset});
  assign prod   = $signed({{4{diff[4]}}, diff}) * $signed({5'b0, scale});
  assign result = sat_out(prod);

endmodule

// File: rtl/dequant_stream_ctrl.sv
// Streams packed INT4 words through one dequant lane, one INT8 element per cycle,
// with a per-group scale/offset table. Output mode selected by DEQ_SIGNED_OUT_EN.
module dequant_stream_ctrl
  import dequant_pkg::*;
#(
  parameter int NPW        = 8,
  parameter int GROUP_SIZE = 32,
  parameter int NUM_GROUPS = 16,
  parameter int CNT_W      = 16,
  localparam int AW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  input  logic [4*NPW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [3:0]       cfg_scale,
  input  logic [3:0]       cfg_offset,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int NW = (NPW > 1) ? $clog2(NPW) : 1;
  localparam int GW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

  state_t           state;
  logic [4*NPW-1:0] word_p0;
  logic [CNT_W-1:0] words_left;
  logic [NW-1:0]    nib_idx;
  logic [GW-1:0]    grp_cnt;
  logic [AW-1:0]    grp_idx;
  logic [NIB_W-1:0] scale_tab  [NUM_GROUPS];
  logic [NIB_W-1:0] offset_tab [NUM_GROUPS];
  logic [NIB_W-1:0] nib;
  logic [OUT_W-1:0] lane_out;
  logic             issue;
  logic             last_nib;

  assign busy     = (state != IDLE);
  assign in_ready = (state == FETCH);
  assign issue    = (state == DRAIN) && (!out_valid || out_ready);
  assign last_nib = (nib_idx == NW'(NPW - 1));
  assign nib      = word_p0[nib_idx*NIB_W +: NIB_W];

  dequant_lane u_lane (
    .nib    (nib),
    .scale  (scale_tab[grp_idx]),
    .offset (offset_tab[grp_idx]),
    .result (lane_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GROUPS; i++) begin
        scale_tab[i]  <= NIB_W'(1);
        offset_tab[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      scale_tab[cfg_addr]  <= cfg_scale;
      offset_tab[cfg_addr] <= cfg_offset;
    end
  end

  // Stage p0 holds the fetched word; the lane result is registered into out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      word_p0    <= '0;
      words_left <= '0;
      nib_idx    <= '0;
      grp_cnt    <= '0;
      grp_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        out_data  <= lane_out;
        out_valid <= 1'b1;
        out_last  <= last_nib && (words_left == '0);
        nib_idx   <= last_nib ? '0 : nib_idx + 1'b1;
        if (grp_cnt == GW'(GROUP_SIZE - 1)) begin
          grp_cnt <= '0;
          grp_idx <= (NUM_GROUPS > 1) ? grp_idx + 1'b1 : '0;
        end else begin
          grp_cnt <= grp_cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            words_left <= num_words;
            nib_idx    <= '0;
            grp_cnt    <= '0;
            grp_idx    <= '0;
            state      <= (num_words == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (in_valid) begin
            word_p0    <= in_data;
            words_left <= words_left - 1'b1;
            nib_idx    <= '0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (issue && last_nib) state <= (words_left == '0) ? DONE : FETCH;
        end
        DONE: begin
          if (!out_valid || out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
